// File: rtl/tp_page_sched_pkg.sv
// Shared types and helpers for the test-point page scheduler.
package tp_sched_pkg;

  localparam int unsigned TP_PAGE_W = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BLANK = 2'd1,
    ST_FRZ   = 2'd2
  } tp_state_e;

  // Round-robin successor: the last page wraps back to page 0.
  function automatic logic [TP_PAGE_W-1:0] page_next(input logic [TP_PAGE_W-1:0] p,
                                                     input int unsigned npages);
    if (32'(p) + 32'd1 >= npages) return '0;
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/tp_page_sched_dwell_timer.sv
// Scan dwell counter: counts enabled cycles and pulses tc on the Nth one.
module tp_dwell_timer #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tc
);

  logic [DWELL_W-1:0] cnt;
  logic               active;

  assign active = en && (dwell != '0);
  // Compare with >= so a dwell shortened mid-count still terminates.
  assign tc = active && (({1'b0, cnt} + (DWELL_W+1)'(1)) >= {1'b0, dwell});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tp_page_sched.sv
// Selects which debug page drives the test-point header, with blanking on
// page changes, round-robin scan and an arm/trigger freeze.
module tp_page_sched
  import tp_sched_pkg::*;
#(
  parameter int unsigned NPAGES    = 4,
  parameter int unsigned TPW       = 16,
  parameter int unsigned BLANK_CYC = 4,
  parameter int unsigned DWELL_W   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NPAGES*TPW-1:0] PAGE_DATA,
  input  logic                  SEL_WE,
  input  logic [TP_PAGE_W-1:0]  SEL_IN,
  input  logic                  SCAN_ENA,
  input  logic [DWELL_W-1:0]    SCAN_DWELL,
  input  logic                  ARM,
  input  logic                  TRIG,
  output logic [TPW-1:0]        TP_OUT,
  output logic [TPW-1:0]        TP_DIR,
  output logic [TP_PAGE_W-1:0]  PAGE,
  output logic                  BLANKING,
  output logic                  FROZEN,
  output logic                  SEL_ERR
);

  localparam int unsigned BW = $clog2(BLANK_CYC + 1);
  localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYC - 1);

  tp_state_e              state;
  logic [BW-1:0]          blank_cnt;
  logic [TP_PAGE_W-1:0]   page;
  logic [TP_PAGE_W-1:0]   pending;
  logic [TP_PAGE_W-1:0]   pend_nxt;
  logic [TPW-1:0]         tp_out;
  logic [TPW-1:0]         page_word;
  logic                   trig_q;
  logic                   sel_err;
  logic                   sel_ok;
  logic                   sel_valid;
  logic                   trig_fire;
  logic                   dwell_en;
  logic                   dwell_clr;
  logic                   dwell_tc;

  assign sel_ok    = 32'(SEL_IN) < NPAGES;
  assign sel_valid = SEL_WE && sel_ok;
  assign trig_fire = TRIG && !trig_q && ARM;
  assign pend_nxt  = sel_valid ? SEL_IN : pending;
  assign page_word = PAGE_DATA[TPW*int'(page) +: TPW];

  // Dwell runs only in RUN; it restarts whenever the displayed page changes.
  assign dwell_en  = (state == ST_RUN) && SCAN_ENA;
  assign dwell_clr = !SCAN_ENA
                  || ((state == ST_RUN) && !trig_fire && sel_valid && (SEL_IN != page))
                  || ((state == ST_FRZ) && !ARM && (pend_nxt != page));

  tp_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk   (CLK),
    .rst   (RST),
    .clr   (dwell_clr),
    .en    (dwell_en),
    .dwell (SCAN_DWELL),
    .tc    (dwell_tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_BLANK;
      blank_cnt <= BLANK_INIT;
      page      <= '0;
      pending   <= '0;
      tp_out    <= '0;
      trig_q    <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      trig_q  <= TRIG;
      sel_err <= SEL_WE && !sel_ok;
      unique case (state)
        ST_RUN: begin
          tp_out <= page_word;
          if (trig_fire) begin
            state   <= ST_FRZ;
            pending <= pend_nxt == pending && !sel_valid ? page : pend_nxt;
          end else if (sel_valid) begin
            // Any valid select in an advance cycle suppresses the advance.
            if (SEL_IN != page) begin
              page      <= SEL_IN;
              state     <= ST_BLANK;
              blank_cnt <= BLANK_INIT;
            end
          end else if (dwell_tc) begin
            page      <= page_next(page, NPAGES);
            state     <= ST_BLANK;
            blank_cnt <= BLANK_INIT;
          end
        end
        ST_BLANK: begin
          tp_out <= '0;
          if (sel_valid) begin
            page      <= SEL_IN;
            blank_cnt <= BLANK_INIT;
          end else if (blank_cnt == '0) begin
            state <= ST_RUN;
          end else begin
            blank_cnt <= blank_cnt - 1'b1;
          end
        end
        ST_FRZ: begin
          pending <= pend_nxt;
          if (!ARM) begin
            if (pend_nxt != page) begin
              page      <= pend_nxt;
              state     <= ST_BLANK;
              blank_cnt <= BLANK_INIT;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        default: begin
          state     <= ST_BLANK;
          blank_cnt <= BLANK_INIT;
        end
      endcase
    end
  end

  assign TP_OUT   = tp_out;
  assign TP_DIR   = '0;
  assign PAGE     = page;
  assign BLANKING = (state == ST_BLANK);
  assign FROZEN   = (state == ST_FRZ);
  assign SEL_ERR  = sel_err;

endmodule

// File: tb/tb_tp_page_sched.sv
// Bench for tp_page_sched: directed vector table, corner sequences and a
// randomized run against a cycle-level behavioural model.
module tb_tp_page_sched;

  localparam int NP        = 4;
  localparam int BLANK_CYC = 4;
  localparam int MD_SHOW   = 0;
  localparam int MD_BLANK  = 1;
  localparam int MD_HOLD   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pdata;
  logic        sel_we;
  logic [3:0]  sel_in;
  logic        scan_ena;
  logic [15:0] scan_dwell;
  logic        arm;
  logic        trig;
  logic [15:0] tp_out;
  logic [15:0] tp_dir;
  logic [3:0]  page;
  logic        blanking;
  logic        frozen;
  logic        sel_err;

  int total = 0;
  int bad   = 0;

  tp_page_sched #(
    .NPAGES    (NP),
    .TPW       (16),
    .BLANK_CYC (BLANK_CYC),
    .DWELL_W   (16)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .PAGE_DATA  (pdata),
    .SEL_WE     (sel_we),
    .SEL_IN     (sel_in),
    .SCAN_ENA   (scan_ena),
    .SCAN_DWELL (scan_dwell),
    .ARM        (arm),
    .TRIG       (trig),
    .TP_OUT     (tp_out),
    .TP_DIR     (tp_dir),
    .PAGE       (page),
    .BLANKING   (blanking),
    .FROZEN     (frozen),
    .SEL_ERR    (sel_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode, blank cycles still to show, RUN cycles seen.
  int          m_mode;
  int          m_left;
  int          m_runs;
  int          m_page;
  int          m_pend;
  bit          m_trig;
  bit          m_err;
  logic [15:0] m_out;

  function automatic void m_reset();
    m_mode = MD_BLANK;
    m_left = BLANK_CYC;
    m_runs = 0;
    m_page = 0;
    m_pend = 0;
    m_trig = 1'b0;
    m_err  = 1'b0;
    m_out  = '0;
  endfunction

  function automatic void m_blank();
    m_mode = MD_BLANK;
    m_left = BLANK_CYC;
    m_runs = 0;
  endfunction

  function automatic void m_step();
    bit rise, valid, due;
    int sel;
    rise   = trig && !m_trig;
    m_trig = trig;
    sel    = int'(sel_in);
    valid  = sel_we && (sel < NP);
    m_err  = sel_we && !valid;
    case (m_mode)
      MD_SHOW: begin
        m_out = pdata[m_page*16 +: 16];
        due   = 1'b0;
        if (scan_ena && scan_dwell != 0) begin
          m_runs++;
          if (m_runs >= int'(scan_dwell)) begin
            due    = 1'b1;
            m_runs = 0;
          end
        end
        if (arm && rise) begin
          m_mode = MD_HOLD;
          m_pend = valid ? sel : m_page;
        end else if (valid) begin
          if (sel != m_page) begin
            m_page = sel;
            m_blank();
          end
        end else if (due) begin
          m_page = (m_page + 1) % NP;
          m_blank();
        end
      end
      MD_BLANK: begin
        m_out = '0;
        if (valid) begin
          m_page = sel;
          m_left = BLANK_CYC;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = MD_SHOW;
        end
      end
      default: begin
        if (valid) m_pend = sel;
        if (!arm) begin
          if (m_pend != m_page) begin
            m_page = m_pend;
            m_blank();
          end else begin
            m_mode = MD_SHOW;
          end
        end
      end
    endcase
    if (!scan_ena) m_runs = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_tp_out", 32'(tp_out), 32'(m_out));
    chk("m_page", 32'(page), 32'(m_page));
    chk("m_blanking", 32'(blanking), 32'(m_mode == MD_BLANK));
    chk("m_frozen", 32'(frozen), 32'(m_mode == MD_HOLD));
    chk("m_sel_err", 32'(sel_err), 32'(m_err));
    chk("tp_dir", 32'(tp_dir), 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [3:0]  e_page;
    logic [15:0] e_tp;
    logic        e_blank;
    logic        e_err;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'd0, 4'd0, 16'h1234, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'd2, 4'd2, 16'h1234, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'd0, 4'd2, 16'h0000, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'd0, 4'd2, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'd0, 4'd2, 16'h0000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'd0, 4'd2, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'd0, 4'd2, 16'hBEEF, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'd2, 4'd2, 16'hBEEF, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'd5, 4'd2, 16'hBEEF, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 4'd0, 4'd2, 16'hBEEF, 1'b0, 1'b0};

    rst        = 1'b1;
    pdata      = {16'h3333, 16'hBEEF, 16'h5555, 16'h1234};
    sel_we     = 1'b0;
    sel_in     = '0;
    scan_ena   = 1'b0;
    scan_dwell = '0;
    arm        = 1'b0;
    trig       = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_tp_out", 32'(tp_out), 32'h0);
    chk("rst_page", 32'(page), 32'h0);
    chk("rst_blanking", 32'(blanking), 32'h1);
    chk("rst_frozen", 32'(frozen), 32'h0);
    chk("rst_sel_err", 32'(sel_err), 32'h0);
    rst = 1'b0;

    // Reset release, page select, same-page select, out-of-range select.
    for (int i = 0; i < 14; i++) begin
      sel_we = tbl[i].we;
      sel_in = tbl[i].sel;
      tick();
      chk($sformatf("vec%0d_page", i), 32'(page), 32'(tbl[i].e_page));
      chk($sformatf("vec%0d_tp", i), 32'(tp_out), 32'(tbl[i].e_tp));
      chk($sformatf("vec%0d_blank", i), 32'(blanking), 32'(tbl[i].e_blank));
      chk($sformatf("vec%0d_err", i), 32'(sel_err), 32'(tbl[i].e_err));
    end
    sel_we = 1'b0;

    // Scan from page 3 wraps to page 0 after exactly 10 RUN cycles.
    sel_we = 1'b1; sel_in = 4'd3; tick();
    sel_we = 1'b0; ticks(5);
    chk("scan_pre_tp", 32'(tp_out), 32'h3333);
    scan_ena = 1'b1; scan_dwell = 16'd10;
    ticks(9);
    chk("scan_9_page", 32'(page), 32'd3);
    tick();
    chk("scan_wrap_page", 32'(page), 32'd0);
    chk("scan_wrap_blank", 32'(blanking), 32'd1);
    scan_ena = 1'b0; ticks(5);
    chk("scan_p0_tp", 32'(tp_out), 32'h1234);
    // A select in the advance cycle wins over the advance.
    scan_ena = 1'b1; ticks(9);
    sel_we = 1'b1; sel_in = 4'd2; tick();
    chk("scan_sel_wins", 32'(page), 32'd2);
    chk("scan_sel_blank", 32'(blanking), 32'd1);
    sel_we = 1'b0; scan_ena = 1'b0; ticks(5);
    chk("scan_p2_tp", 32'(tp_out), 32'hBEEF);

    // Freeze holds the word while page data moves underneath.
    arm = 1'b1; trig = 1'b1; tick();
    chk("frz_frozen", 32'(frozen), 32'd1);
    chk("frz_tp", 32'(tp_out), 32'hBEEF);
    trig = 1'b0; pdata[47:32] = 16'h0F0F; ticks(3);
    chk("frz_hold_tp", 32'(tp_out), 32'hBEEF);
    sel_we = 1'b1; sel_in = 4'd1; tick();
    sel_we = 1'b0; tick();
    chk("frz_pend_page", 32'(page), 32'd2);
    chk("frz_still", 32'(frozen), 32'd1);
    arm = 1'b0; tick();
    chk("frz_exit_page", 32'(page), 32'd1);
    chk("frz_exit_blank", 32'(blanking), 32'd1);
    chk("frz_exit_frozen", 32'(frozen), 32'd0);
    arm = 1'b1; tick();
    trig = 1'b1; tick();
    chk("blank_trig_nofrz", 32'(frozen), 32'd0);
    chk("blank_trig_blank", 32'(blanking), 32'd1);
    trig = 1'b0; ticks(2);
    chk("frz_p1_pre", 32'(tp_out), 32'h0);
    tick();
    chk("frz_p1_tp", 32'(tp_out), 32'h5555);

    // Asynchronous reset from FRZ, asserted between clock edges.
    trig = 1'b1; tick();
    chk("rst_frz_pre", 32'(frozen), 32'd1);
    trig = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("arst_tp_out", 32'(tp_out), 32'h0);
    chk("arst_page", 32'(page), 32'h0);
    chk("arst_blanking", 32'(blanking), 32'h1);
    chk("arst_frozen", 32'(frozen), 32'h0);
    chk("arst_sel_err", 32'(sel_err), 32'h0);
    arm = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      sel_we = ($urandom_range(0, 9) == 0);
      sel_in = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 49) == 0) scan_ena = ~scan_ena;
      if ($urandom_range(0, 29) == 0) scan_dwell = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) arm = ~arm;
      trig = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) pdata = {$urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
